gamma_out_sel: RTL
==================

# gamma_out_sel

Output stage placed directly downstream of the gamma LUT stage. Receives the raw pixel, the sqrt-corrected and square-corrected pixel triplets, and the video sync/enable signals, which are not delayed by the LUT stage. Aligns the sync signals to the LUT latency and selects bypass, sqrt or square from a slide-switch setting. The mode changes only on a frame boundary, so no output frame ever mixes two curves.

## Interface
- ROM_LATENCY, 1, cycles from R/G/B at the LUT input to valid *_sqrt/*_square outputs
- VS_POL, 1, active level of in_vsync (1 = active-high)
- DEBOUNCE_CYCLES, 1000000, number of stable cycles required before a switch change is accepted
- clk  in  1  pixel clock, single clock domain
- rst_n  in  1  synchronous, active-low reset
- sw_mode  in  2  asynchronous slide switches; bit1 = gamma enable, bit0 = square select
- in_vsync, in_hsync, in_de  in  1 each  sync/enable, aligned with R/G/B at the LUT input
- R, G, B  in  8 each  raw pixel, same cycle as the LUT input
- R_sqrt, G_sqrt, B_sqrt  in  8 each  LUT sqrt outputs, ROM_LATENCY cycles after R/G/B
- R_square, G_square, B_square  in  8 each  LUT square outputs, ROM_LATENCY cycles after R/G/B
- out_R, out_G, out_B  out  8 each  selected pixel
- out_vsync, out_hsync, out_de  out  1 each  sync/enable aligned with out_R/G/B
- active_mode  out  2  mode applied to the current output frame
- mode_chg  out  1  one-cycle pulse when active_mode takes a new value
- frame_cnt  out  16  count of output frame starts

## Operation
- **Mode encoding:**
  - 00 and 01 = bypass
  - 10 = sqrt (brighten)
  - 11 = square (darken)
- **Switch path:**
  - sw_mode passes through a 2-FF synchronizer, then the debouncer, into pending_mode.
  - Debouncer: a counter clears whenever the synchronized value differs from the candidate value; the candidate is updated at the same time.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the value unchanged, the debounced value takes the candidate.
- **Alignment:**
  - Raw R/G/B are delayed ROM_LATENCY cycles so they line up with the LUT outputs.
  - in_vsync/hsync/de are delayed ROM_LATENCY+1 cycles so they line up with the registered outputs.
- **Frame boundary:**
  - Edge detection runs on the ROM_LATENCY-delayed vsync; the edge is the transition to level VS_POL.
  - On that cycle: active_mode <= pending_mode, frame_cnt increments, and mode_chg = 1 if the new mode differs from the old.
  - frame_cnt wraps from 0xFFFF to 0x0000.
- **Selection:**
  - Output is registered.
  - When delayed de = 1, out_R/G/B = the triplet chosen by active_mode.
  - When delayed de = 0, out_R/G/B = 0.
  - All three channels always use the same mode.
- **Switch toggled mid-frame:** no effect until the next frame edge. If the switch toggles several times within one frame, only the pending value at the edge is applied.
- **Simultaneous events:** a debounce completion and a vsync edge in the same cycle apply the old pending_mode; the new value applies at the following frame edge.

## Timing
- Pixel latency, R/G/B input to out_R/G/B: ROM_LATENCY+1 cycles (2 at default).
- Sync latency equals pixel latency exactly.
- Mode latency: debounce time + 2 synchronizer cycles + time until the next frame edge.
- Reset (rst_n low at a clk edge):
  - out_R/G/B = 0; out_vsync/hsync/de = 0.
  - active_mode = 00, pending_mode = 00, mode_chg = 0, frame_cnt = 0.
  - Delay lines, synchronizer and debounce counter clear.
- Reset mid-frame: outputs stay blanked (de = 0) until the delay lines refill. The first out_de can assert ROM_LATENCY+1 cycles after release. Bypass mode holds until the first frame edge.
- The edge detector's previous-vsync register resets to the inactive level. A vsync already active at reset release therefore counts as a frame edge.

## Configuration
- GAMMA_OUT_SEL_DEBOUNCE_EN defined: debouncer is instantiated as described above.
- GAMMA_OUT_SEL_DEBOUNCE_EN undefined: pending_mode takes the synchronized switch value every cycle. DEBOUNCE_CYCLES is ignored and no counter logic is generated.

## Structure
- Package gamma_pkg holds:
  - the mode encoding constants MODE_BYPASS, MODE_SQRT and MODE_SQUARE;
  - a 2-bit mode typedef;
  - the default pixel width (8).
- Sub-module gamma_sw_debounce: 2-FF synchronizer plus the debounce counter, parameterized on DEBOUNCE_CYCLES and width.
- The top level holds the delay lines, the frame-edge logic and the output mux.

## Test plan
- Reset, then sw_mode=00 with one 4x4 frame ramp R=G=B=n → out equals input 2 cycles later; sync signals equally delayed; active_mode=00.
- sw_mode=10 set mid-frame (DEBOUNCE_CYCLES=4) → current frame stays bypass. At the next vsync edge: mode_chg pulses, active_mode=10, and pixel 0x40 outputs R_sqrt(0x40).
- sw_mode=11 → after the next frame edge, out equals the square LUT values. During blanking, out_R/G/B = 0 whatever values are on the LUT inputs.
- Glitch on sw_mode of 2 cycles with DEBOUNCE_CYCLES=4 → pending_mode unchanged, no mode_chg. Repeat with the macro undefined → change applied at the next frame edge.
- 65537 short frames → frame_cnt wraps to 0x0001.
- rst_n low mid-line → next cycle all outputs 0. After release, active_mode=00 until a frame edge; first valid out_de appears 2 cycles after in_de.

Source files
------------

// File: rtl/gamma_pkg.sv
// rtl/gamma_pkg.sv - mode encoding, pixel width and pipeline stage type for the gamma output stage
package gamma_pkg;

  localparam int unsigned PIXEL_W = 8;

  typedef logic [1:0] mode_t;

  // 00 and 01 both mean bypass; bit1 enables gamma, bit0 picks square over sqrt
  localparam mode_t MODE_BYPASS = 2'b00;
  localparam mode_t MODE_SQRT   = 2'b10;
  localparam mode_t MODE_SQUARE = 2'b11;

  typedef struct packed {
    logic               vs;
    logic               hs;
    logic               de;
    logic [PIXEL_W-1:0] r;
    logic [PIXEL_W-1:0] g;
    logic [PIXEL_W-1:0] b;
  } pix_stage_t;

endpackage

// File: rtl/gamma_sw_debounce.sv
// rtl/gamma_sw_debounce.sv - switch synchronizer plus debounce counter (counter only with GAMMA_OUT_SEL_DEBOUNCE_EN)
module gamma_sw_debounce
  import gamma_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned W               = $bits(mode_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] sw_o
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;

  // two-stage synchronizer for the asynchronous slide switches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef GAMMA_OUT_SEL_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     cand_q, cand_d;
  logic [W-1:0]     deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // any change restarts the stability count; a full run of stable cycles accepts the candidate
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // debounce state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign sw_o = deb_q;
`else
  assign sw_o = sync2_q;
`endif

endmodule

// File: rtl/gamma_out_sel.sv
// rtl/gamma_out_sel.sv - gamma output stage: sync alignment, frame-locked mode select (GAMMA_OUT_SEL_DEBOUNCE_EN enables debounce)
module gamma_out_sel
  import gamma_pkg::*;
#(
  parameter int unsigned ROM_LATENCY     = 1,
  parameter logic        VS_POL          = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         sw_mode,
  input  logic               in_vsync,
  input  logic               in_hsync,
  input  logic               in_de,
  input  logic [PIXEL_W-1:0] R,
  input  logic [PIXEL_W-1:0] G,
  input  logic [PIXEL_W-1:0] B,
  input  logic [PIXEL_W-1:0] R_sqrt,
  input  logic [PIXEL_W-1:0] G_sqrt,
  input  logic [PIXEL_W-1:0] B_sqrt,
  input  logic [PIXEL_W-1:0] R_square,
  input  logic [PIXEL_W-1:0] G_square,
  input  logic [PIXEL_W-1:0] B_square,
  output logic [PIXEL_W-1:0] out_R,
  output logic [PIXEL_W-1:0] out_G,
  output logic [PIXEL_W-1:0] out_B,
  output logic               out_vsync,
  output logic               out_hsync,
  output logic               out_de,
  output logic [1:0]         active_mode,
  output logic               mode_chg,
  output logic [15:0]        frame_cnt
);

  mode_t      pending_mode;
  pix_stage_t in_stage;
  pix_stage_t dly_tail;

  gamma_sw_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .W               ($bits(mode_t))
  ) u_sw_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_i  (sw_mode),
    .sw_o  (pending_mode)
  );

  assign in_stage = '{vs: in_vsync, hs: in_hsync, de: in_de, r: R, g: G, b: B};

  // raw pixel and sync delay line, ROM_LATENCY deep, so they meet the LUT outputs
  for (genvar k = 0; k < ROM_LATENCY; k++) begin : g_dly
    pix_stage_t q;
    pix_stage_t src;
    if (k == 0) begin : g_first
      assign src = in_stage;
    end else begin : g_next
      assign src = g_dly[k-1].q;
    end
    // one delay stage
    always_ff @(posedge clk) begin
      if (!rst_n) q <= '0;
      else        q <= src;
    end
  end

  assign dly_tail = g_dly[ROM_LATENCY-1].q;

  logic       vs_prev_q;
  logic       vs_edge;
  mode_t      active_q, active_d;
  logic       mode_chg_q, mode_chg_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  pix_stage_t out_q, out_d;

  // frame starts on the delayed vsync entering its active level
  assign vs_edge = (dly_tail.vs == VS_POL) && (vs_prev_q != VS_POL);

  // frame-boundary mode latch and the blanked, mode-selected output pixel
  always_comb begin
    active_d    = active_q;
    frame_cnt_d = frame_cnt_q;
    mode_chg_d  = 1'b0;
    out_d       = '0;
    out_d.vs    = dly_tail.vs;
    out_d.hs    = dly_tail.hs;
    out_d.de    = dly_tail.de;
    if (vs_edge) begin
      active_d    = pending_mode;
      frame_cnt_d = frame_cnt_q + 16'd1;
      mode_chg_d  = (pending_mode != active_q);
    end
    // active_d already carries the new mode on the edge cycle, so that pixel belongs to the new frame
    if (dly_tail.de) begin
      if (active_d == MODE_SQRT) begin
        out_d.r = R_sqrt;
        out_d.g = G_sqrt;
        out_d.b = B_sqrt;
      end else if (active_d == MODE_SQUARE) begin
        out_d.r = R_square;
        out_d.g = G_square;
        out_d.b = B_square;
      end else begin
        out_d.r = dly_tail.r;
        out_d.g = dly_tail.g;
        out_d.b = dly_tail.b;
      end
    end
  end

  // output and frame-state registers; previous vsync resets inactive so an active vsync at release counts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_prev_q   <= ~VS_POL;
      active_q    <= MODE_BYPASS;
      mode_chg_q  <= 1'b0;
      frame_cnt_q <= '0;
      out_q       <= '0;
    end else begin
      vs_prev_q   <= dly_tail.vs;
      active_q    <= active_d;
      mode_chg_q  <= mode_chg_d;
      frame_cnt_q <= frame_cnt_d;
      out_q       <= out_d;
    end
  end

  assign out_R       = out_q.r;
  assign out_G       = out_q.g;
  assign out_B       = out_q.b;
  assign out_vsync   = out_q.vs;
  assign out_hsync   = out_q.hs;
  assign out_de      = out_q.de;
  assign active_mode = active_q;
  assign mode_chg    = mode_chg_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
